// File: rtl/param_sync_fifo.sv
// Single-clock FIFO with binary pointers, occupancy count, threshold
// flags, sticky error flags and selectable registered / FWFT read port.
module param_sync_fifo #(
    parameter int DATASIZE      = 8,
    parameter int ADDRESS_BITS  = 9,
    parameter int AFULL_THRESH  = (1 << ADDRESS_BITS) - 4,
    parameter int AEMPTY_THRESH = 4,
    parameter bit FWFT          = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  winc,
    input  logic [DATASIZE-1:0]   wdata,
    input  logic                  rinc,
    output logic [DATASIZE-1:0]   rdata,
    output logic                  rvalid,
    output logic                  wfull,
    output logic                  rempty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDRESS_BITS:0] count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int DEPTH = 1 << ADDRESS_BITS;
    localparam int CW    = ADDRESS_BITS + 1;

    logic [DATASIZE-1:0] mem [DEPTH];
    logic [CW-1:0]       wptr;
    logic [CW-1:0]       rptr;
    logic [CW-1:0]       wptr_next;
    logic [CW-1:0]       rptr_next;
    logic [CW-1:0]       count_next;
    logic                wr_ok;
    logic                rd_ok;

    assign wr_ok = winc & ~wfull;
    assign rd_ok = rinc & ~rempty;

    // Occupancy is the pointer distance; modulo arithmetic handles wrap.
    assign count = wptr - rptr;

    // Next-state pointers and occupancy feed the registered flags.
    always_comb begin
        wptr_next  = wptr + CW'(wr_ok);
        rptr_next  = rptr + CW'(rd_ok);
        count_next = wptr_next - rptr_next;
    end

    // Pointers, status flags and sticky error flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr         <= '0;
            rptr         <= '0;
            wfull        <= 1'b0;
            rempty       <= 1'b1;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            wptr         <= wptr_next;
            rptr         <= rptr_next;
            wfull        <= (count_next == CW'(DEPTH));
            rempty       <= (count_next == '0);
            almost_full  <= (int'(count_next) >= AFULL_THRESH);
            almost_empty <= (int'(count_next) <= AEMPTY_THRESH);
            if (winc && wfull) overflow <= 1'b1;
            if (rinc && rempty) underflow <= 1'b1;
        end
    end

    // Storage array; contents are never cleared, pointers define validity.
    always_ff @(posedge clk) begin
        if (!rst && wr_ok) mem[wptr[ADDRESS_BITS-1:0]] <= wdata;
    end

    if (FWFT) begin : g_fwft
        // Head word shown combinationally; forced to zero while empty.
        assign rdata  = rempty ? '0 : mem[rptr[ADDRESS_BITS-1:0]];
        assign rvalid = ~rempty;
    end else begin : g_reg
        logic [DATASIZE-1:0] rdata_q;
        logic                rvalid_q;

        // Registered read port: one-cycle latency, data held between reads.
        always_ff @(posedge clk) begin
            if (rst) begin
                rdata_q  <= '0;
                rvalid_q <= 1'b0;
            end else begin
                rvalid_q <= rd_ok;
                if (rd_ok) rdata_q <= mem[rptr[ADDRESS_BITS-1:0]];
            end
        end

        assign rdata  = rdata_q;
        assign rvalid = rvalid_q;
    end

endmodule

// File: tb/tb_param_sync_fifo.sv
// Scoreboard bench: both read modes driven in parallel and checked
// against a queue model of the FIFO contents.
module tb_param_sync_fifo;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       winc = 1'b0;
    logic       rinc = 1'b0;
    logic [7:0] wdata = 8'h00;

    logic [7:0] rdata0, rdata1;
    logic       rvalid0, rvalid1;
    logic       wfull0, wfull1;
    logic       rempty0, rempty1;
    logic       afull0, afull1;
    logic       aempty0, aempty1;
    logic [2:0] count0, count1;
    logic       ovf0, ovf1;
    logic       udf0, udf1;

    int checks = 0;
    int errors = 0;

    int q[$];
    int exp_q[$];
    int last0 = 0;
    bit rv_m = 1'b0;
    bit ovf_m = 1'b0;
    bit udf_m = 1'b0;
    bit started = 1'b0;

    always #5 clk = ~clk;

    param_sync_fifo #(
        .DATASIZE(8), .ADDRESS_BITS(2), .AFULL_THRESH(3),
        .AEMPTY_THRESH(1), .FWFT(1'b0)
    ) u_reg (
        .clk(clk), .rst(rst), .winc(winc), .wdata(wdata),
        .rinc(rinc), .rdata(rdata0), .rvalid(rvalid0),
        .wfull(wfull0), .rempty(rempty0), .almost_full(afull0),
        .almost_empty(aempty0), .count(count0),
        .overflow(ovf0), .underflow(udf0)
    );

    param_sync_fifo #(
        .DATASIZE(8), .ADDRESS_BITS(2), .AFULL_THRESH(3),
        .AEMPTY_THRESH(1), .FWFT(1'b1)
    ) u_fwft (
        .clk(clk), .rst(rst), .winc(winc), .wdata(wdata),
        .rinc(rinc), .rdata(rdata1), .rvalid(rvalid1),
        .wfull(wfull1), .rempty(rempty1), .almost_full(afull1),
        .almost_empty(aempty1), .count(count1),
        .overflow(ovf1), .underflow(udf1)
    );

    task automatic chk(string n, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", n, act, req);
        end
    endtask

    // Reference model: a queue of stored words with capacity 4.
    always @(posedge clk) begin : model
        bit full, empty, wr, rd;
        started = 1'b1;
        if (rst) begin
            q.delete();
            exp_q.delete();
            last0 = 0;
            rv_m  = 1'b0;
            ovf_m = 1'b0;
            udf_m = 1'b0;
        end else begin
            full  = (q.size() == 4);
            empty = (q.size() == 0);
            wr = winc && !full;
            rd = rinc && !empty;
            if (winc && full) ovf_m = 1'b1;
            if (rinc && empty) udf_m = 1'b1;
            rv_m = rd;
            if (rd) begin
                last0 = q.pop_front();
                exp_q.push_back(last0);
            end
            if (wr) q.push_back(int'(wdata));
        end
    end

    // Monitor: status checks every cycle, data popped on rvalid.
    always @(negedge clk) begin : mon
        int n;
        n = q.size();
        if (started) begin
            chk("count0", 32'(count0), n);
            chk("count1", 32'(count1), n);
            chk("rempty0", rempty0, n == 0);
            chk("rempty1", rempty1, n == 0);
            chk("wfull0", wfull0, n == 4);
            chk("wfull1", wfull1, n == 4);
            chk("afull0", afull0, n >= 3);
            chk("afull1", afull1, n >= 3);
            chk("aempty0", aempty0, n <= 1);
            chk("aempty1", aempty1, n <= 1);
            chk("overflow0", ovf0, ovf_m);
            chk("overflow1", ovf1, ovf_m);
            chk("underflow0", udf0, udf_m);
            chk("underflow1", udf1, udf_m);
            chk("rvalid0", rvalid0, rv_m);
            if (rvalid0) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_unexpected rdata=%0h required=none",
                             rdata0);
                end else begin
                    chk("sb_rdata0", 32'(rdata0), exp_q.pop_front());
                end
            end else begin
                chk("hold_rdata0", 32'(rdata0), last0);
            end
            chk("rvalid1", rvalid1, n != 0);
            if (n != 0) chk("head_rdata1", 32'(rdata1), q[0]);
        end
    end

    task automatic step(bit w, bit r, logic [7:0] d, bit rs);
        @(posedge clk);
        #1;
        winc  = w;
        rinc  = r;
        wdata = d;
        rst   = rs;
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00, 1'b0);
    endtask

    initial begin
        bit w, r, rs;
        int wbias;
        // Reset with requests asserted: they must be ignored.
        winc = 1'b1;
        rinc = 1'b1;
        wdata = 8'hEE;
        step(1'b1, 1'b1, 8'hEE, 1'b1);
        step(1'b0, 1'b0, 8'h00, 1'b0);
        @(negedge clk);
        chk("rst_rdata1", 32'(rdata1), 0);
        chk("rst_rdata0", 32'(rdata0), 0);

        // Fill then drain in order.
        step(1'b1, 1'b0, 8'h11, 1'b0);
        step(1'b1, 1'b0, 8'h22, 1'b0);
        step(1'b1, 1'b0, 8'h33, 1'b0);
        step(1'b1, 1'b0, 8'h44, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 8'h00, 1'b0);
        idle(1);

        // Overflow on full, then drain.
        step(1'b1, 1'b0, 8'h11, 1'b0);
        step(1'b1, 1'b0, 8'h22, 1'b0);
        step(1'b1, 1'b0, 8'h33, 1'b0);
        step(1'b1, 1'b0, 8'h44, 1'b0);
        step(1'b1, 1'b0, 8'h55, 1'b0);
        step(1'b1, 1'b1, 8'h66, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 8'h00, 1'b0);

        // Underflow on empty, then write+read together while empty.
        step(1'b0, 1'b1, 8'h00, 1'b0);
        step(1'b1, 1'b1, 8'h77, 1'b0);
        step(1'b0, 1'b1, 8'h00, 1'b0);
        idle(1);

        // Steady state at count 2 with concurrent traffic.
        step(1'b1, 1'b0, 8'h80, 1'b0);
        step(1'b1, 1'b0, 8'h81, 1'b0);
        for (int i = 0; i < 10; i++)
            step(1'b1, 1'b1, 8'(8'h82 + i), 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 8'h00, 1'b0);

        // Head word visible without a read, then reset mid-stream.
        step(1'b1, 1'b0, 8'hA5, 1'b0);
        idle(1);
        step(1'b0, 1'b1, 8'h00, 1'b0);
        step(1'b1, 1'b0, 8'h01, 1'b0);
        step(1'b1, 1'b0, 8'h02, 1'b0);
        step(1'b1, 1'b0, 8'h03, 1'b0);
        step(1'b1, 1'b1, 8'h04, 1'b1);
        step(1'b0, 1'b0, 8'h00, 1'b0);
        @(negedge clk);
        chk("midrst_rdata1", 32'(rdata1), 0);
        chk("midrst_count", 32'(count0), 0);

        // Randomized traffic with shifting bias and rare resets.
        for (int i = 0; i < 600; i++) begin
            wbias = ((i / 100) % 2 == 0) ? 70 : 30;
            w  = ($urandom_range(0, 99) < wbias);
            r  = ($urandom_range(0, 99) < (100 - wbias));
            rs = ($urandom_range(0, 99) == 0);
            step(w, r, 8'($urandom_range(0, 255)), rs);
        end

        for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 8'h00, 1'b0);
        idle(2);
        @(negedge clk);
        chk("sb_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/param_sync_fifo.md
PARAM_SYNC_FIFO -- requirements
Module: param_sync_fifo

Interface
REQ-001 SHALL provide parameter DATASIZE, default 8, data word width in bits.
REQ-002 SHALL provide parameter ADDRESS_BITS, default 9, storage depth DEPTH = 2^ADDRESS_BITS words.
REQ-003 SHALL provide parameter AFULL_THRESH, default DEPTH-4; almost_full asserts when count >= AFULL_THRESH.
REQ-004 SHALL provide parameter AEMPTY_THRESH, default 4; almost_empty asserts when count <= AEMPTY_THRESH.
REQ-005 SHALL provide parameter FWFT, default 0; 0 = registered-read mode, 1 = first-word-fall-through mode.
REQ-006 SHALL provide the following ports:
- clk  input  1  single clock; all state on its rising edge.
- rst  input  1  reset; synchronous and active-high.
- winc  input  1  write request.
- wdata  input  DATASIZE  write data.
- rinc  input  1  read request (pop).
- rdata  output  DATASIZE  read data.
- rvalid  output  1  rdata valid strobe (mode 0); equals ~rempty (mode 1).
- wfull  output  1  FIFO holds DEPTH words.
- rempty  output  1  FIFO holds 0 words.
- almost_full  output  1  threshold flag.
- almost_empty  output  1  threshold flag.
- count  output  ADDRESS_BITS+1  current occupancy, 0..DEPTH.
- overflow  output  1  sticky: write attempted while full.
- underflow  output  1  sticky: read attempted while empty.

Function
REQ-007 Write accepted (wr_ok) SHALL be winc & ~wfull; read accepted (rd_ok) SHALL be rinc & ~rempty; both evaluated from registered flags of the current cycle.
REQ-008 On wr_ok, wdata SHALL be stored at write address wptr[ADDRESS_BITS-1:0], then wptr increments by 1.
REQ-009 On rd_ok, rptr SHALL increment by 1.
REQ-010 Pointers SHALL be ADDRESS_BITS+1 bits binary and wrap modulo 2^(ADDRESS_BITS+1); no gray coding.
REQ-011 count SHALL update next cycle: +1 on wr_ok only, -1 on rd_ok only, unchanged on both or neither; count SHALL equal wptr-rptr at all times.
REQ-012 wfull, rempty, almost_full, almost_empty SHALL be registered and derived from next-cycle count (visible in the same cycle as the updated count).
REQ-013 Simultaneous winc and rinc while full: read accepted, write rejected, count -> DEPTH-1, overflow set.
REQ-014 Simultaneous winc and rinc while empty: write accepted, read rejected, count -> 1, underflow set.
REQ-015 Simultaneous accepted write and read (0<count<DEPTH): count unchanged, flags unchanged.
REQ-016 overflow SHALL set on winc & wfull, underflow on rinc & rempty; both hold until rst.
REQ-017 FWFT=0: on rd_ok, rdata SHALL register mem[rptr] at that edge; rvalid SHALL pulse high one cycle after rd_ok (latency 1); rdata SHALL hold its value otherwise.
REQ-018 FWFT=1: rdata SHALL continuously show mem[rptr] (head word); rvalid = ~rempty; rd_ok advances to the next word in the following cycle.
REQ-019 Write-to-read latency: word written at edge N SHALL produce rempty=0 after edge N, readable from cycle N+1.
REQ-020 Data SHALL emerge in exact write order; no word lost or duplicated across pointer wrap.

Reset
REQ-021 With rst high at a clk edge: wptr=rptr=0, count=0, rempty=1, wfull=0, almost_empty=1, almost_full=0, overflow=0, underflow=0, rvalid=0, rdata=0.
REQ-022 Reset mid-operation SHALL discard all stored words; memory contents need no clearing; winc/rinc during rst SHALL be ignored.

Verification (DATASIZE=8, ADDRESS_BITS=2, DEPTH=4, AFULL_THRESH=3, AEMPTY_THRESH=1)
REQ-023 Write 0x11,0x22,0x33,0x44, then 4 reads (FWFT=0) -> rdata 0x11,0x22,0x33,0x44 each one cycle after rinc, rvalid pulses; count 4 -> 0; wfull 1 after 4th write, rempty 1 after 4th read.
REQ-024 Full FIFO, winc with 0x55 -> not stored, count stays 4, overflow=1; subsequent reads return 0x11..0x44 only.
REQ-025 Empty FIFO, rinc -> rdata unchanged, rvalid=0, underflow=1, count stays 0.
REQ-026 count=2, winc+rinc together for 10 cycles with incrementing data -> count stays 2, pointers wrap, read sequence matches write sequence.
REQ-027 Thresholds: count 0->1->2->3 -> almost_empty 1,1,0,0; almost_full 0,0,0,1.
REQ-028 FWFT=1: write 0xA5 -> next cycle rdata=0xA5, rvalid=1 without rinc; rinc -> rempty=1; then rst mid-stream with count=3 -> count=0, rempty=1, flags cleared.
